// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
//
// Owns the single write port of the double-buffered pixel RAM. The port is
// shared between the host pixel stream and a fill engine that clears the back
// buffer to one colour. The block also schedules the front/back buffer swap so
// that a swap only takes effect on a display frame boundary.
//
// Build option: define FB_ARB_CLEAR_EN to include the fill engine and the
// round-robin arbiter. Without it, the host owns the write port outright,
// clear_start/clear_color are ignored, and clear_busy is held at 0.
//
// RAM address layout: {buffer_select, pixel_address}. Writes always go to the
// back buffer (~front_buf). The buffer select is taken at grant time, so every
// write issued before the swap edge lands in the old back buffer.

module framebuffer_write_arbiter #(
   parameter int BITS_PER_PIXEL = 16,
   parameter int ADDR_BITS      = 10
) (
   input  logic                      clk,
   input  logic                      reset,

   // host pixel stream
   input  logic                      host_valid,
   output logic                      host_ready,
   input  logic [ADDR_BITS-1:0]      host_addr,
   input  logic [BITS_PER_PIXEL-1:0] host_data,

   // fill engine control
   input  logic                      clear_start,
   input  logic [BITS_PER_PIXEL-1:0] clear_color,
   output logic                      clear_busy,

   // buffer swap control
   input  logic                      swap_req,
   input  logic                      frame_done,
   output logic                      swap_pending,
   output logic                      front_buf,

   // RAM write port
   output logic                      ram_we,
   output logic [ADDR_BITS:0]        ram_addr,
   output logic [BITS_PER_PIXEL-1:0] ram_wdata
);

   // Which requester won the most recent contended cycle.
   typedef enum logic {
      GRANT_HOST = 1'b0,
      GRANT_FILL = 1'b1
   } grant_t;

   // Swap scheduler states.
   typedef enum logic {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_t;

   // Grant decisions for the current cycle.
   logic                      grant_host;
   logic                      grant_fill;

   // Fill engine state. It is constant when the fill engine is not built.
   logic                      fill_busy;
   logic [ADDR_BITS-1:0]      fill_cnt;
   logic [BITS_PER_PIXEL-1:0] fill_color;

   swap_state_t               swap_state;

`ifdef FB_ARB_CLEAR_EN

   // The host is blocked while a swap is pending. This keeps host pixels for
   // the next frame out of the buffer that is about to be shown.
   logic   host_req;
   grant_t last_grant;

   // Round-robin grant. A lone requester always wins. On contention, the
   // requester that did not win last time gets the port.
   // NOTE: every always_comb output is given a default first, so that no path
   // leaves it unassigned and a latch is never inferred.
   always_comb begin
      host_req   = 1'b0;
      grant_host = 1'b0;
      grant_fill = 1'b0;

      host_req   = host_valid & ~swap_pending;
      grant_host = host_req  & (~fill_busy | (last_grant == GRANT_FILL));
      grant_fill = fill_busy & (~host_req  | (last_grant == GRANT_HOST));
   end

   // Fill engine and round-robin history.
   // clear_start always restarts the sweep at pixel 0 with the new colour,
   // even when a sweep is already running. A fill grant in that same cycle
   // still writes at its old address.
   // NOTE: all sequential state uses non-blocking assignments, so every
   // register samples values from before the edge, whatever the statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_busy  <= 1'b0;
         fill_cnt   <= '0;
         fill_color <= '0;
         last_grant <= GRANT_HOST;
      end else begin
         if (host_req && fill_busy) begin
            last_grant <= grant_fill ? GRANT_FILL : GRANT_HOST;
         end

         if (clear_start) begin
            fill_busy  <= 1'b1;
            fill_cnt   <= '0;
            fill_color <= clear_color;
         end else if (grant_fill) begin
            fill_cnt <= fill_cnt + ADDR_BITS'(1);
            if (fill_cnt == {ADDR_BITS{1'b1}}) begin
               fill_busy <= 1'b0;
            end
         end
      end
   end

`else

   // Without the fill engine, the host owns the port whenever no swap is pending.
   assign grant_host = host_valid & ~swap_pending;
   assign grant_fill = 1'b0;
   assign fill_busy  = 1'b0;
   assign fill_cnt   = '0;
   assign fill_color = '0;

   // clear_start and clear_color have no function in this build.
   logic unused_clear_inputs;
   assign unused_clear_inputs = &{1'b0, clear_start, clear_color};

`endif

   assign host_ready = grant_host;
   assign clear_busy = fill_busy;

   // Registered RAM write port. The winner of cycle N appears on the port in
   // cycle N+1. The buffer select is the back buffer at the moment of grant.
   // Address and data keep their last values on idle cycles; only ram_we drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else if (grant_host) begin
         ram_we    <= 1'b1;
         ram_addr  <= {~front_buf, host_addr};
         ram_wdata <= host_data;
      end else if (grant_fill) begin
         ram_we    <= 1'b1;
         ram_addr  <= {~front_buf, fill_cnt};
         ram_wdata <= fill_color;
      end else begin
         ram_we    <= 1'b0;
      end
   end

   // Swap scheduler. A request waits for a frame boundary at which no fill is
   // running. The swap then flips front_buf on that edge. A frame_done that
   // arrives together with swap_req only arms the swap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         swap_state   <= SWAP_IDLE;
         swap_pending <= 1'b0;
         front_buf    <= 1'b0;
      end else begin
         case (swap_state)
            SWAP_IDLE: begin
               if (swap_req) begin
                  swap_state   <= SWAP_PENDING;
                  swap_pending <= 1'b1;
               end
            end
            SWAP_PENDING: begin
               if (frame_done && !fill_busy) begin
                  swap_state   <= SWAP_IDLE;
                  swap_pending <= 1'b0;
                  front_buf    <= ~front_buf;
               end
            end
            default: begin
               swap_state   <= SWAP_IDLE;
               swap_pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Testbench for framebuffer_write_arbiter.
// Expected RAM writes are queued as stimulus is applied. A monitor on the
// falling edge pops and compares each write the DUT issues. Scenarios that
// depend on the fill engine follow FB_ARB_CLEAR_EN, as the design does.

module tb_framebuffer_write_arbiter;

   localparam int BPP = 16;
   localparam int AB  = 10;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           host_valid = 1'b0;
   logic           host_ready;
   logic [AB-1:0]  host_addr = '0;
   logic [BPP-1:0] host_data = '0;
   logic           clear_start = 1'b0;
   logic [BPP-1:0] clear_color = '0;
   logic           clear_busy;
   logic           swap_req = 1'b0;
   logic           frame_done = 1'b0;
   logic           swap_pending;
   logic           front_buf;
   logic           ram_we;
   logic [AB:0]    ram_addr;
   logic [BPP-1:0] ram_wdata;

   typedef struct packed {
      logic [AB:0]    addr;
      logic [BPP-1:0] data;
   } wr_t;

   wr_t sb[$];
   int  checks   = 0;
   int  failures = 0;
   bit  mon_en   = 1'b0;

   framebuffer_write_arbiter #(
      .BITS_PER_PIXEL(BPP),
      .ADDR_BITS(AB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .host_valid(host_valid),
      .host_ready(host_ready),
      .host_addr(host_addr),
      .host_data(host_data),
      .clear_start(clear_start),
      .clear_color(clear_color),
      .clear_busy(clear_busy),
      .swap_req(swap_req),
      .frame_done(frame_done),
      .swap_pending(swap_pending),
      .front_buf(front_buf),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata)
   );

   always #5 clk = ~clk;

   // Write monitor: compare each issued RAM write against the queue head.
   always @(negedge clk) begin
      wr_t exp_w;
      if (mon_en && ram_we === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_write: got addr=%h data=%h expected no write", ram_addr, ram_wdata);
         end else begin
            exp_w = sb.pop_front();
            if (ram_addr !== exp_w.addr || ram_wdata !== exp_w.data) begin
               failures++;
               $display("FAIL sb_write: got addr=%h data=%h expected addr=%h data=%h",
                        ram_addr, ram_wdata, exp_w.addr, exp_w.data);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      mon_en      = 1'b0;
      reset       = 1'b1;
      host_valid  = 1'b0;
      host_addr   = '0;
      host_data   = '0;
      clear_start = 1'b0;
      clear_color = '0;
      swap_req    = 1'b0;
      frame_done  = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic push(input logic [AB:0] a, input logic [BPP-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      sb.push_back(w);
   endtask

   task automatic test_reset;
      do_reset();
      checks += 7;
      if (host_ready   !== 1'b0) begin failures++; $display("FAIL rst_host_ready: got %b expected 0", host_ready); end
      if (clear_busy   !== 1'b0) begin failures++; $display("FAIL rst_clear_busy: got %b expected 0", clear_busy); end
      if (swap_pending !== 1'b0) begin failures++; $display("FAIL rst_swap_pending: got %b expected 0", swap_pending); end
      if (front_buf    !== 1'b0) begin failures++; $display("FAIL rst_front_buf: got %b expected 0", front_buf); end
      if (ram_we       !== 1'b0) begin failures++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
      if (ram_addr     !== '0)   begin failures++; $display("FAIL rst_ram_addr: got %h expected 000", ram_addr); end
      if (ram_wdata    !== '0)   begin failures++; $display("FAIL rst_ram_wdata: got %h expected 0000", ram_wdata); end
   endtask

   task automatic test_host_write;
      logic [AB-1:0]  addrs [3];
      logic [BPP-1:0] datas [3];
      addrs[0] = 10'h3FF; datas[0] = 16'hFFFF;
      addrs[1] = 10'h000; datas[1] = 16'h0001;
      addrs[2] = 10'h2AA; datas[2] = 16'h5555;
      do_reset();
      step();
      host_valid = 1'b1; host_addr = 10'h005; host_data = 16'hABCD;
      #1;
      checks++;
      if (host_ready !== 1'b1) begin failures++; $display("FAIL host_ready_first: got %b expected 1", host_ready); end
      push({1'b1, 10'h005}, 16'hABCD);
      step();
      host_valid = 1'b0;
      checks += 3;
      if (ram_we    !== 1'b1)     begin failures++; $display("FAIL host_ram_we: got %b expected 1", ram_we); end
      if (ram_addr  !== 11'h405)  begin failures++; $display("FAIL host_ram_addr: got %h expected 405", ram_addr); end
      if (ram_wdata !== 16'hABCD) begin failures++; $display("FAIL host_ram_wdata: got %h expected abcd", ram_wdata); end
      // back-to-back host writes at the address and data extremes
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         host_valid = 1'b1; host_addr = addrs[i]; host_data = datas[i];
         #1;
         checks++;
         if (host_ready !== 1'b1) begin failures++; $display("FAIL host_ready_b2b: got %b expected 1", host_ready); end
         push({1'b1, addrs[i]}, datas[i]);
      end
      step();
      host_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL host_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_fill;
      logic [AB-1:0] a;
      do_reset();
      step();
      clear_start = 1'b1; clear_color = 16'h1234;
      #1;
      checks++;
      if (clear_busy !== 1'b0) begin failures++; $display("FAIL fill_busy_early: got %b expected 0", clear_busy); end
`ifdef FB_ARB_CLEAR_EN
      for (int i = 0; i < 1024; i++) begin
         a = i[AB-1:0];
         push({1'b1, a}, 16'h1234);
      end
      for (int i = 0; i < 1024; i++) begin
         step();
         clear_start = 1'b0; clear_color = 16'hFFFF;
         #1;
         checks++;
         if (clear_busy !== 1'b1) begin failures++; $display("FAIL fill_busy: got %b expected 1 at %0d", clear_busy, i); end
      end
`else
      step();
      clear_start = 1'b0;
      #1;
`endif
      step();
      checks++;
      if (clear_busy !== 1'b0) begin failures++; $display("FAIL fill_busy_end: got %b expected 0", clear_busy); end
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL fill_drain: got %0d pending expected 0", sb.size()); end
   endtask

`ifdef FB_ARB_CLEAR_EN
   task automatic test_fill_restart;
      logic [AB-1:0] a;
      do_reset();
      step();
      clear_start = 1'b1; clear_color = 16'hAAAA;
      // fill grants at pixels 0..5 with the first colour; the restart cycle still writes pixel 5
      for (int i = 0; i < 6; i++) begin
         a = i[AB-1:0];
         push({1'b1, a}, 16'hAAAA);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         clear_start = 1'b0;
      end
      step();
      clear_start = 1'b1; clear_color = 16'hBBBB;
      for (int i = 0; i < 1024; i++) begin
         a = i[AB-1:0];
         push({1'b1, a}, 16'hBBBB);
      end
      for (int i = 0; i < 1024; i++) begin
         step();
         clear_start = 1'b0;
      end
      step();
      checks++;
      if (clear_busy !== 1'b0) begin failures++; $display("FAIL restart_busy_end: got %b expected 0", clear_busy); end
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL restart_drain: got %0d pending expected 0", sb.size()); end
   endtask
`endif

   task automatic test_contention;
      logic [AB-1:0] a;
      int hk;
      bit exp_ready;
      bit exp_busy;
      hk = 0;
      do_reset();
      step();
      clear_start = 1'b1; clear_color = 16'h5A5A;
`ifdef FB_ARB_CLEAR_EN
      // Fill wins the first contended cycle because the last grant is the host.
      // After that, the two requesters alternate.
      for (int i = 0; i < 2048; i++) begin
         step();
         clear_start = 1'b0;
         host_valid  = 1'b1;
         host_addr   = hk[AB-1:0] + 10'h100;
         host_data   = 16'h8000 | hk[BPP-1:0];
         #1;
         exp_ready = i[0];
         exp_busy  = (i < 2047);
         checks += 2;
         if (host_ready !== exp_ready) begin failures++; $display("FAIL rr_host_ready: got %b expected %b at %0d", host_ready, exp_ready, i); end
         if (clear_busy !== exp_busy)  begin failures++; $display("FAIL rr_clear_busy: got %b expected %b at %0d", clear_busy, exp_busy, i); end
         if (i[0] == 1'b0) begin
            a = (i / 2);
            push({1'b1, a}, 16'h5A5A);
         end else begin
            push({1'b1, host_addr}, host_data);
            hk++;
         end
      end
`else
      for (int i = 0; i < 8; i++) begin
         step();
         clear_start = 1'b0;
         host_valid  = 1'b1;
         host_addr   = hk[AB-1:0] + 10'h100;
         host_data   = 16'h8000 | hk[BPP-1:0];
         #1;
         checks += 2;
         if (host_ready !== 1'b1) begin failures++; $display("FAIL nofill_host_ready: got %b expected 1 at %0d", host_ready, i); end
         if (clear_busy !== 1'b0) begin failures++; $display("FAIL nofill_clear_busy: got %b expected 0 at %0d", clear_busy, i); end
         push({1'b1, host_addr}, host_data);
         hk++;
      end
`endif
      step();
      host_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL rr_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_swap;
      do_reset();
      step();
      swap_req = 1'b1;
      #1;
      checks++;
      if (swap_pending !== 1'b0) begin failures++; $display("FAIL swap_pending_early: got %b expected 0", swap_pending); end
      // three cycles of host traffic blocked while the swap is pending
      for (int k = 1; k <= 3; k++) begin
         step();
         swap_req   = (k == 2);
         frame_done = (k == 3);
         host_valid = 1'b1; host_addr = 10'h033; host_data = 16'h0C0C;
         #1;
         checks += 3;
         if (swap_pending !== 1'b1) begin failures++; $display("FAIL swap_pending: got %b expected 1 at %0d", swap_pending, k); end
         if (host_ready   !== 1'b0) begin failures++; $display("FAIL swap_host_blocked: got %b expected 0 at %0d", host_ready, k); end
         if (front_buf    !== 1'b0) begin failures++; $display("FAIL swap_front_early: got %b expected 0 at %0d", front_buf, k); end
      end
      step();
      swap_req = 1'b0; frame_done = 1'b0;
      #1;
      checks += 3;
      if (front_buf    !== 1'b1) begin failures++; $display("FAIL swap_front: got %b expected 1", front_buf); end
      if (swap_pending !== 1'b0) begin failures++; $display("FAIL swap_pending_clr: got %b expected 0", swap_pending); end
      if (host_ready   !== 1'b1) begin failures++; $display("FAIL swap_host_resume: got %b expected 1", host_ready); end
      push({1'b0, 10'h033}, 16'h0C0C);
      step();
      host_valid = 1'b0;
      // simultaneous request and frame boundary only arms the swap
      swap_req = 1'b1; frame_done = 1'b1;
      step();
      swap_req = 1'b0; frame_done = 1'b0;
      #1;
      checks += 2;
      if (swap_pending !== 1'b1) begin failures++; $display("FAIL simul_pending: got %b expected 1", swap_pending); end
      if (front_buf    !== 1'b1) begin failures++; $display("FAIL simul_front: got %b expected 1", front_buf); end
      step();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      #1;
      checks += 2;
      if (front_buf    !== 1'b0) begin failures++; $display("FAIL simul_front_after: got %b expected 0", front_buf); end
      if (swap_pending !== 1'b0) begin failures++; $display("FAIL simul_pending_after: got %b expected 0", swap_pending); end
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL swap_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_swap_during_fill;
      logic [AB-1:0] a;
      do_reset();
      step();
      clear_start = 1'b1; clear_color = 16'h0F0F;
`ifdef FB_ARB_CLEAR_EN
      for (int i = 0; i < 1024; i++) begin
         a = i[AB-1:0];
         push({1'b1, a}, 16'h0F0F);
      end
`endif
      step();
      clear_start = 1'b0; swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      #1;
      checks++;
      if (swap_pending !== 1'b1) begin failures++; $display("FAIL sdf_pending: got %b expected 1", swap_pending); end
      repeat (50) step();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      #1;
`ifdef FB_ARB_CLEAR_EN
      checks += 2;
      if (swap_pending !== 1'b1) begin failures++; $display("FAIL sdf_ignored_pending: got %b expected 1", swap_pending); end
      if (front_buf    !== 1'b0) begin failures++; $display("FAIL sdf_ignored_front: got %b expected 0", front_buf); end
      repeat (1000) step();
      checks += 2;
      if (clear_busy   !== 1'b0) begin failures++; $display("FAIL sdf_busy_end: got %b expected 0", clear_busy); end
      if (swap_pending !== 1'b1) begin failures++; $display("FAIL sdf_still_pending: got %b expected 1", swap_pending); end
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      #1;
`endif
      checks += 2;
      if (front_buf    !== 1'b1) begin failures++; $display("FAIL sdf_front: got %b expected 1", front_buf); end
      if (swap_pending !== 1'b0) begin failures++; $display("FAIL sdf_pending_clr: got %b expected 0", swap_pending); end
      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sdf_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_reset_mid_op;
      bit exp_busy;
`ifdef FB_ARB_CLEAR_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      do_reset();
      mon_en = 1'b0;
      // first make front_buf = 1, so that the reset must visibly clear it
      step(); swap_req = 1'b1;
      step(); swap_req = 1'b0; frame_done = 1'b1;
      step(); frame_done = 1'b0;
      #1;
      checks++;
      if (front_buf !== 1'b1) begin failures++; $display("FAIL rmo_front_pre: got %b expected 1", front_buf); end
      step(); clear_start = 1'b1; clear_color = 16'h7777;
      step(); clear_start = 1'b0; swap_req = 1'b1;
      step(); swap_req = 1'b0;
      repeat (10) step();
      checks += 3;
      if (swap_pending !== 1'b1)     begin failures++; $display("FAIL rmo_pending_pre: got %b expected 1", swap_pending); end
      if (clear_busy   !== exp_busy) begin failures++; $display("FAIL rmo_busy_pre: got %b expected %b", clear_busy, exp_busy); end
      if (ram_we       !== exp_busy) begin failures++; $display("FAIL rmo_we_pre: got %b expected %b", ram_we, exp_busy); end
      #2;
      reset = 1'b1;
      #1;
      checks += 7;
      if (host_ready   !== 1'b0) begin failures++; $display("FAIL rmo_host_ready: got %b expected 0", host_ready); end
      if (clear_busy   !== 1'b0) begin failures++; $display("FAIL rmo_clear_busy: got %b expected 0", clear_busy); end
      if (swap_pending !== 1'b0) begin failures++; $display("FAIL rmo_swap_pending: got %b expected 0", swap_pending); end
      if (front_buf    !== 1'b0) begin failures++; $display("FAIL rmo_front_buf: got %b expected 0", front_buf); end
      if (ram_we       !== 1'b0) begin failures++; $display("FAIL rmo_ram_we: got %b expected 0", ram_we); end
      if (ram_addr     !== '0)   begin failures++; $display("FAIL rmo_ram_addr: got %h expected 000", ram_addr); end
      if (ram_wdata    !== '0)   begin failures++; $display("FAIL rmo_ram_wdata: got %h expected 0000", ram_wdata); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      mon_en = 1'b1;
      // the abandoned fill must not resume
      repeat (2) step();
      checks += 2;
      if (clear_busy !== 1'b0) begin failures++; $display("FAIL rmo_busy_post: got %b expected 0", clear_busy); end
      if (ram_we     !== 1'b0) begin failures++; $display("FAIL rmo_we_post: got %b expected 0", ram_we); end
   endtask

   initial begin
      test_reset();
      test_host_write();
      test_fill();
`ifdef FB_ARB_CLEAR_EN
      test_fill_restart();
`endif
      test_contention();
      test_swap();
      test_swap_during_fill();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
